selector_out_stream: RTL and testbench
======================================

Name: selector_out_stream

Overview:
- Parametrised successor to the two-way output selector. Routes one input stream to one of CHANNELS output streams, chosen per beat by SELECT.
- Uses valid/ready handshakes on the input and on every output.
- Each channel has a DEPTH-entry FIFO, so a stalled consumer blocks only its own channel.
- Sits between a producing pipeline stage and multiple consuming units. Non-selected and idle outputs drive zero, as the existing selector does.

Parameters:
- WIDTH, 32, data width in bits.
- CHANNELS, 4, number of output channels, >= 2.
- DEPTH, 2, entries per channel FIFO, >= 1.
- SEL_W, $clog2(CHANNELS), SELECT width. Localparam, not overridable.

Ports:
- CLK  input  1  sole clock, rising edge.
- RESET  input  1  synchronous, active-high reset.
- IN_VALID  input  1  input beat present.
- IN_READY  output  1  block accepts the input beat this cycle.
- SELECT  input  SEL_W  destination channel of the current input beat.
- DATA_IN  input  WIDTH  input data.
- OUT_VALID  output  CHANNELS  bit i: channel i head entry valid.
- OUT_READY  input  CHANNELS  bit i: consumer i takes the head entry.
- DATA_OUT  output  CHANNELS*WIDTH  slice [i*WIDTH +: WIDTH] is channel i data.
- ERR_SEL  output  1  sticky flag: a beat with SELECT >= CHANNELS was accepted.

Behaviour:
- Interface: one clock CLK; reset RESET is synchronous and active-high. All state updates occur on the rising edge of CLK.

Reset:
- While RESET=1 at an edge, all FIFOs are emptied (pointers and counts = 0) and ERR_SEL is cleared.
- After that edge: OUT_VALID = 0, DATA_OUT = 0, ERR_SEL = 0.
- IN_READY = 0 in any cycle where RESET = 1.
- Reset mid-operation discards all buffered data; no beat is delivered afterwards.

Input handshake:
- Input accept = IN_VALID & IN_READY.
- IN_READY is combinational from SELECT and the selected FIFO's full flag: IN_READY = !RESET & (SELECT >= CHANNELS | !full[SELECT]).
- IN_READY never depends on OUT_READY. A full FIFO refuses a push even when it pops in the same cycle.
- An accepted beat is written to the tail of FIFO[SELECT]. Other channels are unaffected.
- Out-of-range SELECT (possible when CHANNELS is not a power of 2): the beat is accepted and discarded, and ERR_SEL is set at that edge. ERR_SEL stays set until RESET.

Output handshake:
- OUT_VALID[i] = FIFO i non-empty. The signal is registered-state-derived, not combinational from inputs.
- The DATA_OUT slice i equals the FIFO i head entry when OUT_VALID[i] = 1, and all zeros otherwise.
- Pop i = OUT_VALID[i] & OUT_READY[i]. It advances the head at the edge.
- OUT_READY[i] while OUT_VALID[i] = 0 has no effect.
- Once OUT_VALID[i] is high, it holds, and DATA_OUT slice i is stable, until popped.

Timing and ordering:
- Latency: a beat accepted at edge k produces OUT_VALID[SELECT] = 1 from edge k onward, i.e. visible in cycle k+1, when the FIFO was empty.
- Throughput: one beat per cycle into any non-full channel.
- Simultaneous push and pop on a non-full FIFO: both take effect and the count is unchanged. Push and pop on an empty FIFO cannot coincide, since pop requires valid.
- Per-channel order is preserved. There is no ordering relation across channels.

FIFO implementation:
- Read and write pointers are mod DEPTH and wrap from DEPTH-1 to 0.
- Count range is 0..DEPTH; full = (count == DEPTH).
- Count width is $clog2(DEPTH+1).

Test Plan:
1. RESET=1 for 2 cycles with IN_VALID=1 -> IN_READY=0, OUT_VALID=4'b0000, DATA_OUT=0, ERR_SEL=0. Release, then push SELECT=2, DATA_IN=32'hA5A5_0001 -> next cycle OUT_VALID=4'b0100, slice 2=32'hA5A5_0001, other slices 0.
2. OUT_READY=0, push 3 beats to channel 1 (32'h11, 32'h12, 32'h13) with DEPTH=2 -> first two accepted, IN_READY=0 on the third. Setting OUT_READY[1]=1 for one cycle pops 32'h11 and does not admit the stalled beat that cycle; 32'h13 is accepted the following cycle. Output order is 11, 12, 13.
3. Channel 0 full and stalled, alternate SELECT 0/3 every cycle -> beats to channel 3 flow at 1 per 2 cycles, channel-0 beats stall, channel 0 data is unchanged.
4. Steady state with OUT_READY=all 1s, continuous push of incrementing data to channel 2 for 20 cycles -> IN_READY constantly 1, one pop per cycle, pointer wrap exercised, data in order with no gaps.
5. CHANNELS=3 build, push SELECT=3 with DATA_IN=32'hDEAD -> IN_READY=1, no OUT_VALID change, ERR_SEL=1 from next cycle and held through 10 more cycles until RESET.
6. Two entries buffered in channel 0, assert RESET for one cycle mid-stream -> OUT_VALID[0]=0 and slice 0=0 after the edge, and neither entry is ever delivered.

Source files
------------

// File: rtl/selector_out_stream.sv
// selector_out_stream
//   Routes one valid/ready input stream to one of CHANNELS output streams.
//   SELECT chooses the destination of each beat. Each channel has its own
//   DEPTH-entry FIFO, so a stalled consumer blocks only its own channel.
//
// Ports
//   CLK        sole clock, rising edge
//   RESET      synchronous, active-high reset
//   IN_VALID   input beat present
//   IN_READY   beat accepted this cycle (depends on SELECT and full flags only)
//   SELECT     destination channel of the current beat
//   DATA_IN    input data
//   OUT_VALID  bit i: channel i holds a head entry
//   OUT_READY  bit i: consumer i takes the head entry
//   DATA_OUT   slice [i*WIDTH +: WIDTH] is the channel i head, zero when idle
//   ERR_SEL    sticky: a beat with SELECT >= CHANNELS was accepted
module selector_out_stream #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 2,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      IN_VALID,
  output logic                      IN_READY,
  input  logic [SEL_W-1:0]          SELECT,
  input  logic [WIDTH-1:0]          DATA_IN,
  output logic [CHANNELS-1:0]       OUT_VALID,
  input  logic [CHANNELS-1:0]       OUT_READY,
  output logic [CHANNELS*WIDTH-1:0] DATA_OUT,
  output logic                      ERR_SEL
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [CHANNELS-1:0] full;
  logic [CHANNELS-1:0] sel_hit;
  logic                sel_oor;
  logic                sel_full;
  logic                accept;
  logic                err_q;
  logic                err_d;

  // One-hot decode of SELECT; an all-zero result means out of range.
  always_comb begin
    sel_hit = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      sel_hit[c] = (SELECT == SEL_W'(c));
    end
  end

  assign sel_oor  = ~|sel_hit;
  assign sel_full = |(sel_hit & full);
  // Out-of-range beats are always taken (and dropped) so the producer never hangs.
  assign IN_READY = ~RESET & (sel_oor | ~sel_full);
  assign accept   = IN_VALID & IN_READY;

  always_comb begin
    err_d = err_q | (accept & sel_oor);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign ERR_SEL = err_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] wptr_d;
    logic [PTR_W-1:0] rptr_q;
    logic [PTR_W-1:0] rptr_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             push;
    logic             pop;

    assign full[g]      = (cnt_q == CNT_W'(DEPTH));
    assign OUT_VALID[g] = (cnt_q != '0);
    assign push         = accept & sel_hit[g];
    assign pop          = OUT_VALID[g] & OUT_READY[g];

    assign DATA_OUT[g*WIDTH +: WIDTH] = OUT_VALID[g] ? mem_q[rptr_q] : '0;

    always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (push) begin
        wptr_d = (wptr_q == PTR_W'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_d = (rptr_q == PTR_W'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end

    always_ff @(posedge CLK) begin
      if (RESET) begin
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
      end else begin
        wptr_q <= wptr_d;
        rptr_q <= rptr_d;
        cnt_q  <= cnt_d;
      end
    end

    // Storage needs no reset: contents are only visible behind OUT_VALID.
    always_ff @(posedge CLK) begin
      if (push) begin
        mem_q[wptr_q] <= DATA_IN;
      end
    end
  end

endmodule

// File: tb/tb_selector_out_stream.sv
`timescale 1ns/1ps
module tb_selector_out_stream;

  localparam int W  = 32;
  localparam int CH = 4;
  localparam int D  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (4 channels)
  logic          rst;
  logic          in_valid;
  logic [1:0]    sel;
  logic [31:0]   din;
  logic [3:0]    out_ready;
  logic          in_ready;
  logic [3:0]    out_valid;
  logic [127:0]  dout;
  logic          err;

  // Second DUT (3 channels) for out-of-range SELECT
  logic          rst3;
  logic          v3;
  logic [1:0]    sel3;
  logic [31:0]   din3;
  logic [2:0]    ordy3;
  logic          rdy3;
  logic [2:0]    ov3;
  logic [95:0]   dout3;
  logic          err3;

  selector_out_stream #(.WIDTH(W), .CHANNELS(CH), .DEPTH(D)) u_dut (
    .CLK(clk), .RESET(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
    .SELECT(sel), .DATA_IN(din), .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .DATA_OUT(dout), .ERR_SEL(err)
  );

  selector_out_stream #(.WIDTH(W), .CHANNELS(3), .DEPTH(D)) u_dut3 (
    .CLK(clk), .RESET(rst3), .IN_VALID(v3), .IN_READY(rdy3),
    .SELECT(sel3), .DATA_IN(din3), .OUT_VALID(ov3), .OUT_READY(ordy3),
    .DATA_OUT(dout3), .ERR_SEL(err3)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: one queue per channel, updated at each rising edge.
  logic [31:0] mq [CH][$];
  logic        err_m = 1'b0;
  bit          armed = 1'b0;

  always @(posedge clk) begin
    bit acc_m;
    if (rst) begin
      for (int c = 0; c < CH; c++) mq[c].delete();
      err_m = 1'b0;
      armed = 1'b1;
    end else begin
      acc_m = in_valid && (mq[sel].size() < D);
      for (int c = 0; c < CH; c++)
        if (out_ready[c] && mq[c].size() > 0) void'(mq[c].pop_front());
      if (acc_m) mq[sel].push_back(din);
    end
  end

  always @(negedge clk) begin
    logic [3:0]   ev;
    logic [127:0] ed;
    if (armed) begin
      ev = '0;
      ed = '0;
      for (int c = 0; c < CH; c++) begin
        if (mq[c].size() > 0) begin
          ev[c] = 1'b1;
          ed[c*W +: W] = mq[c][0];
        end
      end
      chk("model_out_valid", out_valid, ev);
      chk("model_data_out", dout, ed);
      chk("model_in_ready", in_ready, !rst && (mq[sel].size() < D));
      chk("model_err_sel", err, err_m);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; sel = 2'd0; din = '0; out_ready = '0;
    rst3 = 1'b1; v3 = 1'b0; sel3 = 2'd0; din3 = '0; ordy3 = '0;

    // 1: reset, then single beat to channel 2
    #1; chk("t1_rdy_in_reset", in_ready, 0);
    tick(); #1;
    chk("t1_rst_ov", out_valid, 0);
    chk("t1_rst_data", dout, 0);
    chk("t1_rst_err", err, 0);
    chk("t1_rst_rdy", in_ready, 0);
    tick();
    rst = 1'b0; sel = 2'd2; din = 32'hA5A5_0001; in_valid = 1'b1;
    #1; chk("t1_rdy", in_ready, 1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("t1_ov", out_valid, 4'b0100);
    chk("t1_data", dout, 128'h0000_0000_A5A5_0001_0000_0000_0000_0000);
    out_ready = 4'b0100;
    tick();
    out_ready = '0;

    // 2: overfill channel 1
    sel = 2'd1; in_valid = 1'b1; din = 32'h11;
    tick(); din = 32'h12;
    tick(); din = 32'h13;
    #1; chk("t2_full_refuse", in_ready, 0);
    tick();
    out_ready = 4'b0010;
    #1; chk("t2_rdy_indep_of_pop", in_ready, 0);
    chk("t2_head_11", dout[63:32], 32'h11);
    tick();
    out_ready = '0;
    #1; chk("t2_rdy_after_pop", in_ready, 1);
    chk("t2_head_12a", dout[63:32], 32'h12);
    tick();
    in_valid = 1'b0; out_ready = 4'b0010;
    #1; chk("t2_head_12b", dout[63:32], 32'h12);
    tick();
    #1; chk("t2_head_13", dout[63:32], 32'h13);
    tick();
    out_ready = '0;
    #1; chk("t2_empty", out_valid[1], 0);

    // 3: channel 0 full and stalled, alternate 0/3
    sel = 2'd0; in_valid = 1'b1; din = 32'hC0C0_0000;
    tick(); din = 32'hC0C0_0001;
    tick();
    out_ready = 4'b1000;
    for (int i = 0; i < 10; i++) begin
      sel = (i % 2) ? 2'd3 : 2'd0;
      din = 32'h3300_0000 + i;
      #1;
      chk("t3_ready", in_ready, sel == 2'd3);
      chk("t3_ch0_hold", dout[31:0], 32'hC0C0_0000);
      tick();
    end

    // 4: streaming to channel 2
    in_valid = 1'b0; out_ready = '1;
    repeat (3) tick();
    sel = 2'd2; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      din = 32'h4000_0000 + i;
      #1;
      chk("t4_ready", in_ready, 1);
      chk("t4_valid", out_valid[2], i > 0);
      if (i > 0) chk("t4_data", dout[95:64], 32'h4000_0000 + i - 1);
      tick();
    end
    in_valid = 1'b0;
    repeat (2) tick();

    // 6: reset mid-stream discards buffered entries
    out_ready = '0; sel = 2'd0; in_valid = 1'b1; din = 32'h6001;
    tick(); din = 32'h6002;
    tick();
    in_valid = 1'b0;
    #1; chk("t6_buffered", out_valid[0], 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("t6_ov0", out_valid[0], 0);
    chk("t6_slice0", dout[31:0], 0);
    out_ready = '1;
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      chk("t6_no_deliver", out_valid, 0);
    end

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 63) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      sel       = 2'($urandom_range(0, 3));
      din       = $urandom;
      out_ready = 4'($urandom_range(0, 15));
      tick();
    end
    rst = 1'b0; in_valid = 1'b0;

    // 5: out-of-range SELECT on the 3-channel build
    rst3 = 1'b0;
    tick(); #1;
    chk("t5_err_init", err3, 0);
    sel3 = 2'd3; din3 = 32'hDEAD; v3 = 1'b1;
    #1; chk("t5_rdy", rdy3, 1);
    tick();
    v3 = 1'b0;
    #1;
    chk("t5_err_set", err3, 1);
    chk("t5_no_valid", ov3, 0);
    for (int i = 0; i < 10; i++) begin
      tick(); #1;
      chk("t5_err_hold", err3, 1);
    end
    rst3 = 1'b1;
    tick(); #1;
    chk("t5_err_clear", err3, 0);
    chk("t5_rdy_in_reset", rdy3, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
